// File: rtl/rfphoenix_dcache_fill_rd_if.sv
// rtl/rfphoenix_dcache_fill_rd_if.sv - memory bus read-beat interface for the dcache fill reader
//
// Purpose: bundles the bus-side handshake of the line fill reader.
// Signals:
//   cyc_o  bus cycle active (master -> slave)
//   stb_o  beat strobe (master -> slave)
//   adr_o  beat byte address, beat aligned (master -> slave)
//   ack_i  beat acknowledge (slave -> master)
//   err_i  bus error (slave -> master)
//   dat_i  beat read data (slave -> master)
interface rfphoenix_dcache_fill_rd_if #(
  parameter int ADR_W  = 32,
  parameter int BEAT_W = 128
);
  logic              cyc_o;
  logic              stb_o;
  logic [ADR_W-1:0]  adr_o;
  logic              ack_i;
  logic              err_i;
  logic [BEAT_W-1:0] dat_i;

  modport master (output cyc_o, stb_o, adr_o, input ack_i, err_i, dat_i);
  modport slave  (input cyc_o, stb_o, adr_o, output ack_i, err_i, dat_i);
endinterface

// File: rtl/rfphoenix_dcache_fill_rd.sv
// rtl/rfphoenix_dcache_fill_rd.sv - dcache miss reader: burst line fill or single uncached beat
//
// Purpose: on a load miss, reads a cache line beat by beat from the memory bus and presents it
// with a one-cycle write strobe, or returns one uncached beat. Access, bus error and timeout
// faults all finish with a done pulse qualified by fault.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req/req_adr/acr   miss request (sampled only when idle); acr[2]=readable, acr[3]=cachable
//   busy              high whenever not idle
//   bus               memory bus master side (cyc/stb/adr out, ack/err/dat in)
//   wr/wr_adr/wr_line one-cycle line write with line-aligned address and assembled line
//   done/rd_dat/fault completion pulse, beat containing req_adr, fault qualifier
module rfphoenix_dcache_fill_rd #(
  parameter int ADR_W      = 32,
  parameter int BEAT_W     = 128,
  parameter int LINE_BEATS = 4,
  parameter int TMO        = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req,
  input  logic [ADR_W-1:0]               req_adr,
  input  logic [3:0]                     req_acr,
  output logic                           busy,
  rfphoenix_dcache_fill_rd_if.master     bus,
  output logic                           wr,
  output logic [ADR_W-1:0]               wr_adr,
  output logic [BEAT_W*LINE_BEATS-1:0]   wr_line,
  output logic                           done,
  output logic [BEAT_W-1:0]              rd_dat,
  output logic                           fault
);
  localparam int OFF_W = $clog2(BEAT_W / 8);
  localparam int IDX_W = $clog2(LINE_BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam int TMO_W = $clog2(TMO + 1);
  localparam logic [ADR_W-1:0] BEAT_MASK = ~ADR_W'(BEAT_W / 8 - 1);
  localparam logic [ADR_W-1:0] LINE_MASK = ~ADR_W'(BEAT_W / 8 * LINE_BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_BUS, S_GAP, S_UPDATE, S_FAULT} state_t;
  typedef logic [LINE_BEATS-1:0][BEAT_W-1:0] line_t;

  state_t           state_q, state_d;
  logic [ADR_W-1:0] adr_q;         // original request address, selects rd_dat slot
  logic             line_mode_q;
  logic [ADR_W-1:0] cur_adr_q;     // address of the beat being fetched
  logic [CNT_W-1:0] beats_left_q;  // beats not yet acknowledged
  logic [TMO_W-1:0] tmo_q;
  line_t            line_buf_q;    // assembly buffer, overwritten by every fill
  line_t            wr_line_q;     // published copy, stable until the next fill completes
  logic [ADR_W-1:0] wr_adr_q;
  logic [BEAT_W-1:0] rd_dat_q;

  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] req_idx;
  logic [ADR_W-1:0] nxt_adr;
  logic             cyc, stb;

  assign cur_idx = cur_adr_q[OFF_W +: IDX_W];
  assign req_idx = adr_q[OFF_W +: IDX_W];

  // Next beat: bump the beat index and let it wrap inside the same line.
  always_comb begin
    nxt_adr = cur_adr_q & LINE_MASK;
    nxt_adr[OFF_W +: IDX_W] = cur_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cyc     = 1'b0;
    stb     = 1'b0;
    wr      = 1'b0;
    done    = 1'b0;
    fault   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = req_acr[2] ? S_BUS : S_FAULT;
      end
      S_BUS: begin
        cyc = 1'b1;
        stb = 1'b1;
        // err wins over a simultaneous ack
        if (bus.err_i)                         state_d = S_FAULT;
        else if (bus.ack_i)                    state_d = S_GAP;
        else if (tmo_q == TMO_W'(TMO - 1))     state_d = S_FAULT;
      end
      S_GAP: begin
        cyc     = 1'b1;
        state_d = (beats_left_q == '0) ? S_UPDATE : S_BUS;
      end
      S_UPDATE: begin
        wr      = line_mode_q;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        done    = 1'b1;
        fault   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q        <= '0;
      line_mode_q  <= 1'b0;
      cur_adr_q    <= '0;
      beats_left_q <= '0;
      tmo_q        <= '0;
      line_buf_q   <= '0;
      wr_line_q    <= '0;
      wr_adr_q     <= '0;
      rd_dat_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            adr_q        <= req_adr;
            line_mode_q  <= req_acr[3];
            cur_adr_q    <= req_acr[3] ? (req_adr & LINE_MASK) : (req_adr & BEAT_MASK);
            beats_left_q <= req_acr[3] ? CNT_W'(LINE_BEATS) : CNT_W'(1);
            tmo_q        <= '0;
          end
        end
        S_BUS: begin
          if (!bus.err_i) begin
            if (bus.ack_i) begin
              line_buf_q[cur_idx] <= bus.dat_i;
              beats_left_q        <= beats_left_q - CNT_W'(1);
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
        end
        S_GAP: begin
          tmo_q <= '0;
          if (beats_left_q != '0) begin
            cur_adr_q <= nxt_adr;
          end else begin
            // Last beat already sits in line_buf_q: publish results for the UPDATE cycle.
            rd_dat_q <= line_buf_q[req_idx];
            if (line_mode_q) begin
              wr_adr_q  <= adr_q & LINE_MASK;
              wr_line_q <= line_buf_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign bus.cyc_o = cyc;
  assign bus.stb_o = stb;
  assign bus.adr_o = cur_adr_q;
  assign wr_adr    = wr_adr_q;
  assign wr_line   = wr_line_q;
  assign rd_dat    = rd_dat_q;
endmodule

// File: tb/tb_rfphoenix_dcache_fill_rd.sv
// tb/tb_rfphoenix_dcache_fill_rd.sv - scoreboard bench for rfphoenix_dcache_fill_rd
`timescale 1ns/1ps
module tb_rfphoenix_dcache_fill_rd;
  localparam int ADR_W      = 32;
  localparam int BEAT_W     = 128;
  localparam int LINE_BEATS = 4;
  localparam int TMO        = 255;
  localparam int BEAT_BYTES = BEAT_W / 8;
  localparam int LINE_BYTES = BEAT_BYTES * LINE_BEATS;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         req = 1'b0;
  logic [ADR_W-1:0]             req_adr = '0;
  logic [3:0]                   req_acr = '0;
  logic                         busy, wr, done, fault;
  logic [ADR_W-1:0]             wr_adr;
  logic [BEAT_W*LINE_BEATS-1:0] wr_line;
  logic [BEAT_W-1:0]            rd_dat;

  rfphoenix_dcache_fill_rd_if #(.ADR_W(ADR_W), .BEAT_W(BEAT_W)) bif ();

  rfphoenix_dcache_fill_rd #(
    .ADR_W(ADR_W), .BEAT_W(BEAT_W), .LINE_BEATS(LINE_BEATS), .TMO(TMO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_adr(req_adr), .req_acr(req_acr),
    .busy(busy), .bus(bif), .wr(wr), .wr_adr(wr_adr), .wr_line(wr_line),
    .done(done), .rd_dat(rd_dat), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                           flt;
    bit                           line;
    logic [ADR_W-1:0]             base;
    logic [BEAT_W*LINE_BEATS-1:0] line_dat;
    logic [BEAT_W-1:0]            rd;
  } exp_t;

  exp_t             exp_q[$];
  logic [ADR_W-1:0] exp_adr_q[$];

  int checks = 0, errors = 0;
  int wr_cnt = 0, cyc_cnt = 0, stb_cnt = 0;
  int r_lo = 0, r_hi = 0, r_err_beat = -1, r_beat = 0, r_wait = 0, r_dly = 0;
  bit r_noack = 1'b0;
  bit data_idx = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] beat_data(input logic [ADR_W-1:0] a);
    logic [BEAT_W-1:0] d;
    if (data_idx) begin
      d = '0;
      d[31:0] = (a / BEAT_BYTES) % LINE_BEATS;
    end else begin
      d = {a ^ 32'hDEAD_BEEF, a, ~a, a + 32'h1357};
    end
    return d;
  endfunction

  // Reference model: what the request should do on the bus and at completion.
  task automatic model(input logic [ADR_W-1:0] adr, input logic [3:0] acr,
                       input int err_beat, input bit noack);
    exp_t e;
    int nb;
    logic [ADR_W-1:0] first, a;
    nb         = !acr[2] ? 0 : (acr[3] ? LINE_BEATS : 1);
    first      = acr[3] ? (adr / LINE_BYTES) * LINE_BYTES : (adr / BEAT_BYTES) * BEAT_BYTES;
    e.line     = acr[3];
    e.base     = (adr / LINE_BYTES) * LINE_BYTES;
    e.flt      = !acr[2] || (nb > 0 && noack) || (err_beat >= 0 && err_beat < nb);
    e.rd       = beat_data((adr / BEAT_BYTES) * BEAT_BYTES);
    e.line_dat = '0;
    for (int k = 0; k < nb; k++) begin
      a = first + k * BEAT_BYTES;
      e.line_dat[k*BEAT_W +: BEAT_W] = beat_data(a);
      if (!noack && (err_beat < 0 || k < err_beat)) exp_adr_q.push_back(a);
    end
    exp_q.push_back(e);
  endtask

  task automatic setup_resp(input int lo, input int hi, input int err_beat, input bit noack);
    r_lo = lo; r_hi = hi; r_err_beat = err_beat; r_noack = noack;
    r_beat = 0; r_wait = 0; r_dly = $urandom_range(hi, lo);
  endtask

  // Issues one request and waits (bounded) for done; optionally fires a second req while busy.
  task automatic issue(input logic [ADR_W-1:0] adr, input logic [3:0] acr, input int err_beat,
                       input bit noack, input int lo, input int hi, input bit inject,
                       output int lat);
    bit got;
    model(adr, acr, err_beat, noack);
    setup_resp(lo, hi, err_beat, noack);
    @(negedge clk);
    req = 1'b1; req_adr = adr; req_acr = acr;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      lat++;
      if (c == 0) req = 1'b0;
      if (inject && c == 2) begin req = 1'b1; req_adr = 32'hFFFF_FF00; req_acr = 4'b1000; end
      if (inject && c == 3) req = 1'b0;
      if (done) begin got = 1'b1; break; end
    end
    req = 1'b0;
    chk("done_seen", got, 1'b1);
    chk("cyc_at_done", bif.cyc_o, 1'b0);
    repeat (3) @(negedge clk);
    chk("beats_pending", exp_adr_q.size(), 0);
    chk("results_pending", exp_q.size(), 0);
    exp_adr_q.delete();
    exp_q.delete();
  endtask

  // Bus slave and beat monitor.
  initial begin
    bif.ack_i = 1'b0; bif.err_i = 1'b0; bif.dat_i = '0;
    forever begin
      @(negedge clk);
      bif.ack_i = 1'b0; bif.err_i = 1'b0;
      if (rst_n && bif.stb_o) begin
        stb_cnt++;
        if (!r_noack) begin
          if (r_wait >= r_dly) begin
            bif.dat_i = beat_data(bif.adr_o);
            bif.ack_i = 1'b1;
            if (r_beat == r_err_beat) begin
              bif.err_i = 1'b1;
            end else if (exp_adr_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_beat: got adr %0h expected none", bif.adr_o);
            end else begin
              chk("beat_adr", bif.adr_o, exp_adr_q.pop_front());
            end
            r_beat++; r_wait = 0; r_dly = $urandom_range(r_hi, r_lo);
          end else begin
            r_wait++;
          end
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bif.cyc_o) cyc_cnt++;
      if (wr) wr_cnt++;
      if (wr && !done) begin
        checks++; errors++;
        $display("FAIL wr_without_done: got wr=1 done=0 expected done=1");
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          e = exp_q.pop_front();
          chk("fault", fault, e.flt);
          chk("wr", wr, !e.flt && e.line);
          if (!e.flt) begin
            chk("rd_dat", rd_dat, e.rd);
            if (e.line) begin
              chk("wr_adr", wr_adr, e.base);
              chk("wr_line", wr_line, e.line_dat);
            end
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat, w0, c0, s0, nb, eb;
    logic [3:0] acr;
    logic [3:0] acr_tab [5];
    acr_tab[0] = 4'b1100; acr_tab[1] = 4'b0100; acr_tab[2] = 4'b1000;
    acr_tab[3] = 4'b1101; acr_tab[4] = 4'b0110;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cyc", bif.cyc_o, 1'b0);
    chk("rst_stb", bif.stb_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_wr_adr", wr_adr, '0);
    chk("rst_wr_line", wr_line, '0);
    chk("rst_rd_dat", rd_dat, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: cachable fill, ack one cycle after stb, data = beat index
    data_idx = 1'b1;
    w0 = wr_cnt;
    issue(32'h1234, 4'b1100, -1, 1'b0, 1, 1, 1'b0, lat);
    chk("t1_wr_once", wr_cnt - w0, 1);
    chk("t1_rd_dat_beat3", rd_dat, 128'd3);
    data_idx = 1'b0;

    // Minimum latency fill
    issue(32'h0000_5678, 4'b1100, -1, 1'b0, 0, 0, 1'b0, lat);
    chk("min_latency", lat, 2 * LINE_BEATS + 1);

    // 2: uncached single beat
    w0 = wr_cnt;
    issue(32'h40, 4'b0100, -1, 1'b0, 1, 1, 1'b0, lat);
    chk("t2_no_wr", wr_cnt - w0, 0);

    // 3: not readable
    c0 = cyc_cnt;
    issue(32'h800, 4'b1000, -1, 1'b0, 0, 0, 1'b0, lat);
    chk("t3_no_cyc", cyc_cnt - c0, 0);
    chk("t3_latency", lat, 1);

    // 4: bus error on beat 2 (ack asserted alongside err)
    w0 = wr_cnt;
    issue(32'h2000, 4'b1100, 2, 1'b0, 1, 1, 1'b0, lat);
    chk("t4_no_wr", wr_cnt - w0, 0);

    // 5: timeout, then a clean fill
    s0 = stb_cnt;
    issue(32'h3000, 4'b1100, -1, 1'b1, 0, 0, 1'b0, lat);
    checks++;
    if (stb_cnt - s0 < TMO || stb_cnt - s0 > TMO + 1) begin
      errors++;
      $display("FAIL t5_tmo_cycles: got %0d expected %0d..%0d", stb_cnt - s0, TMO, TMO + 1);
    end
    issue(32'h3040, 4'b1100, -1, 1'b0, 0, 2, 1'b0, lat);

    // 6: reset mid-burst, then a fill with an ignored req while busy
    model(32'h4000, 4'b1100, -1, 1'b0);
    setup_resp(1, 1, -1, 1'b0);
    @(negedge clk);
    req = 1'b1; req_adr = 32'h4000; req_acr = 4'b1100;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", bif.cyc_o, 1'b0);
    chk("t6_rst_stb", bif.stb_o, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_wr_line", wr_line, '0);
    exp_q.delete();
    exp_adr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = wr_cnt;
    issue(32'h4010, 4'b1100, -1, 1'b0, 1, 2, 1'b1, lat);
    chk("t6_wr_once", wr_cnt - w0, 1);

    // Randomized mix
    for (int i = 0; i < 25; i++) begin
      acr = acr_tab[$urandom_range(4, 0)];
      nb  = !acr[2] ? 0 : (acr[3] ? LINE_BEATS : 1);
      eb  = (nb > 0 && $urandom_range(4, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
      issue($urandom, acr, eb, 1'b0, 0, 3, 1'b0, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
